// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states
// and byte-enable patterns.
package dm_arbiter_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_B0   = 4'b0001;
   localparam logic [3:0] BE_B1   = 4'b0010;
   localparam logic [3:0] BE_B2   = 4'b0100;
   localparam logic [3:0] BE_B3   = 4'b1000;
   localparam logic [3:0] BE_LO   = 4'b0011;
   localparam logic [3:0] BE_HI   = 4'b1100;
   localparam logic [3:0] BE_ALL  = 4'b1111;

endpackage

// File: rtl/dm_arbiter_be_gen.sv
// Byte-enable generator: access size and address[1:0] to lane enables,
// plus a misalignment / illegal-size flag. Also usable by the CPU store path.
module dm_be_gen
   import dm_arbiter_pkg::*;
(
   input  logic [1:0] size_i,
   input  logic [1:0] addr_i,
   output logic [3:0] be_o,
   output logic       misal_o
);

   always_comb begin
      be_o    = BE_NONE;
      misal_o = 1'b0;
      case (size_i)
         SZ_BYTE: begin
            case (addr_i)
               2'b00:   be_o = BE_B0;
               2'b01:   be_o = BE_B1;
               2'b10:   be_o = BE_B2;
               default: be_o = BE_B3;
            endcase
         end
         SZ_HALF: begin
            be_o    = addr_i[1] ? BE_HI : BE_LO;
            misal_o = addr_i[0];
         end
         SZ_WORD: begin
            be_o    = BE_ALL;
            misal_o = |addr_i;
         end
         default: misal_o = 1'b1;
      endcase
      // Rejected accesses never enable a lane.
      if (misal_o) be_o = BE_NONE;
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter and access sequencer for the single-port data memory.
// IDLE grants and latches a request, ACCESS drives the memory, RESP acks.
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [1:0]  m0_size,
   input  logic        m0_signed,
   input  logic [11:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [1:0]  m1_size,
   input  logic        m1_signed,
   input  logic [11:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic [9:0]  dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_din,
   output logic        dm_wr,
   output logic        dm_signed,
   input  logic [31:0] dm_dout,
   output logic        busy
);

   state_e      state_q;
   logic        last_grant_q, grant_q, we_q;
   logic        m0_ack_q, m1_ack_q, m0_err_q, m1_err_q;
   logic [31:0] m0_rdata_q, m1_rdata_q;
   logic [9:0]  dm_addr_q;
   logic [3:0]  dm_be_q;
   logic [31:0] dm_din_q;
   logic        dm_wr_q, dm_signed_q;

   logic        win;
   logic        sel_we, sel_signed, sel_misal;
   logic [1:0]  sel_size;
   logic [11:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_be;

   // Round-robin favours the port that did not win last time.
   always_comb begin
      if (m0_req && m1_req) win = FIXED_PRIO ? 1'b0 : ~last_grant_q;
      else                  win = ~m0_req;
      sel_we     = win ? m1_we     : m0_we;
      sel_size   = win ? m1_size   : m0_size;
      sel_signed = win ? m1_signed : m0_signed;
      sel_addr   = win ? m1_addr   : m0_addr;
      sel_wdata  = win ? m1_wdata  : m0_wdata;
   end

   dm_be_gen u_be_gen (
      .size_i  (sel_size),
      .addr_i  (sel_addr[1:0]),
      .be_o    (sel_be),
      .misal_o (sel_misal)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         we_q         <= 1'b0;
         m0_ack_q     <= 1'b0;
         m1_ack_q     <= 1'b0;
         m0_err_q     <= 1'b0;
         m1_err_q     <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
         dm_addr_q    <= '0;
         dm_be_q      <= '0;
         dm_din_q     <= '0;
         dm_wr_q      <= 1'b0;
         dm_signed_q  <= 1'b0;
      end else begin
         m0_ack_q <= 1'b0;
         m1_ack_q <= 1'b0;
         m0_err_q <= 1'b0;
         m1_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (m0_req || m1_req) begin
                  grant_q      <= win;
                  last_grant_q <= win;
                  we_q         <= sel_we;
                  dm_addr_q    <= sel_addr[11:2];
                  dm_din_q     <= sel_wdata;
                  if (sel_misal) begin
                     state_q <= RESP;
                     if (win) begin
                        m1_ack_q <= 1'b1; m1_err_q <= 1'b1; m1_rdata_q <= '0;
                     end else begin
                        m0_ack_q <= 1'b1; m0_err_q <= 1'b1; m0_rdata_q <= '0;
                     end
                  end else begin
                     state_q     <= ACCESS;
                     dm_wr_q     <= sel_we;
                     dm_be_q     <= sel_be;
                     dm_signed_q <= sel_signed;
                  end
               end
            end
            ACCESS: begin
               state_q     <= RESP;
               dm_wr_q     <= 1'b0;
               dm_be_q     <= '0;
               dm_signed_q <= 1'b0;
               if (grant_q) begin
                  m1_ack_q   <= 1'b1;
                  m1_rdata_q <= we_q ? '0 : dm_dout;
               end else begin
                  m0_ack_q   <= 1'b1;
                  m0_rdata_q <= we_q ? '0 : dm_dout;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m0_ack    = m0_ack_q;
   assign m1_ack    = m1_ack_q;
   assign m0_err    = m0_err_q;
   assign m1_err    = m1_err_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign dm_addr   = dm_addr_q;
   assign dm_be     = dm_be_q;
   assign dm_din    = dm_din_q;
   assign dm_wr     = dm_wr_q;
   assign dm_signed = dm_signed_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: round-robin and fixed-priority instances
// share stimulus; a byte-lane memory model backs the round-robin instance.
module tb_dm_arbiter;

   logic        clk, rst_n;
   logic        m0_req, m0_we, m0_signed, m1_req, m1_we, m1_signed;
   logic [1:0]  m0_size, m1_size;
   logic [11:0] m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;

   logic        rr_m0_ack, rr_m0_err, rr_m1_ack, rr_m1_err;
   logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_dm_din, rr_dm_dout;
   logic [9:0]  rr_dm_addr;
   logic [3:0]  rr_dm_be;
   logic        rr_dm_wr, rr_dm_signed, rr_busy;

   logic        fx_m0_ack, fx_m0_err, fx_m1_ack, fx_m1_err;
   logic [31:0] fx_m0_rdata, fx_m1_rdata, fx_dm_din, fx_dm_dout;
   logic [9:0]  fx_dm_addr;
   logic [3:0]  fx_dm_be;
   logic        fx_dm_wr, fx_dm_signed, fx_busy;

   logic [31:0] mem [1024];
   int n_checks = 0;
   int n_pass   = 0;

   dm_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_signed(m0_signed),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(rr_m0_ack), .m0_err(rr_m0_err),
      .m0_rdata(rr_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_signed(m1_signed),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(rr_m1_ack), .m1_err(rr_m1_err),
      .m1_rdata(rr_m1_rdata),
      .dm_addr(rr_dm_addr), .dm_be(rr_dm_be), .dm_din(rr_dm_din), .dm_wr(rr_dm_wr),
      .dm_signed(rr_dm_signed), .dm_dout(rr_dm_dout), .busy(rr_busy)
   );

   dm_arbiter #(.FIXED_PRIO(1'b1)) u_fx (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_signed(m0_signed),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(fx_m0_ack), .m0_err(fx_m0_err),
      .m0_rdata(fx_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_signed(m1_signed),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(fx_m1_ack), .m1_err(fx_m1_err),
      .m1_rdata(fx_m1_rdata),
      .dm_addr(fx_dm_addr), .dm_be(fx_dm_be), .dm_din(fx_dm_din), .dm_wr(fx_dm_wr),
      .dm_signed(fx_dm_signed), .dm_dout(fx_dm_dout), .busy(fx_busy)
   );

   assign fx_dm_dout = 32'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lowest(input logic [3:0] be);
      for (int i = 0; i < 4; i++) if (be[i]) return i;
      return 0;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                         input logic [3:0] be);
      logic [31:0] r;
      int off;
      r = old;
      off = lowest(be);
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = din[8*(b-off) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] w, input logic [3:0] be,
                                          input logic sg);
      logic [31:0] raw;
      raw = w >> (8 * lowest(be));
      case ($countones(be))
         1:       return sg ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
         2:       return sg ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   always @(negedge clk) if (rr_dm_wr) mem[rr_dm_addr] <= merge(mem[rr_dm_addr], rr_dm_din, rr_dm_be);
   assign rr_dm_dout = mem_rd(mem[rr_dm_addr], rr_dm_be, rr_dm_signed);

   task automatic run_access(input bit port, input logic we, input logic [1:0] sz,
                             input logic sg, input logic [11:0] ad, input logic [31:0] wd,
                             output int lat, output logic err, output logic [31:0] rd,
                             output int wr_cyc, output logic [3:0] be_seen);
      logic ack;
      if (port) begin
         m1_we = we; m1_size = sz; m1_signed = sg; m1_addr = ad; m1_wdata = wd; m1_req = 1'b1;
      end else begin
         m0_we = we; m0_size = sz; m0_signed = sg; m0_addr = ad; m0_wdata = wd; m0_req = 1'b1;
      end
      lat = -1; wr_cyc = 0; be_seen = '0; err = 1'bx; rd = 'x;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (rr_dm_wr) begin wr_cyc++; be_seen = rr_dm_be; end
         ack = port ? rr_m1_ack : rr_m0_ack;
         if (ack) begin
            lat = i;
            err = port ? rr_m1_err : rr_m0_err;
            rd  = port ? rr_m1_rdata : rr_m0_rdata;
            break;
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({rr_busy, rr_m0_ack, rr_m1_ack, rr_m0_err, rr_m1_err} !== 5'b0)
         $display("FAIL reset_flags got %b want 00000",
                  {rr_busy, rr_m0_ack, rr_m1_ack, rr_m0_err, rr_m1_err});
      else n_pass++;
      n_checks++;
      if ({rr_m0_rdata, rr_m1_rdata} !== 64'h0)
         $display("FAIL reset_rdata got %h want 0", {rr_m0_rdata, rr_m1_rdata});
      else n_pass++;
      n_checks++;
      if ({rr_dm_addr, rr_dm_be, rr_dm_din, rr_dm_wr, rr_dm_signed} !== 48'h0)
         $display("FAIL reset_dm got %h want 0",
                  {rr_dm_addr, rr_dm_be, rr_dm_din, rr_dm_wr, rr_dm_signed});
      else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (rr_busy !== 1'b0) $display("FAIL reset_idle busy got %b want 0", rr_busy);
      else n_pass++;
   endtask

   task automatic test_word();
      int lat, wc; logic err; logic [31:0] rd; logic [3:0] be;
      run_access(0, 1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, lat, err, rd, wc, be);
      n_checks++;
      if (lat !== 2 || wc !== 1 || be !== 4'b1111 || err !== 1'b0 || rd !== 32'h0)
         $display("FAIL word_store lat=%0d wr=%0d be=%b err=%b rd=%h want 2 1 1111 0 0",
                  lat, wc, be, err, rd);
      else n_pass++;
      n_checks++;
      if (mem[4] !== 32'hDEADBEEF) $display("FAIL word_mem got %h want deadbeef", mem[4]);
      else n_pass++;
      run_access(0, 1'b0, 2'b10, 1'b1, 12'h010, 32'h0, lat, err, rd, wc, be);
      n_checks++;
      if (lat !== 2 || wc !== 0 || err !== 1'b0 || rd !== 32'hDEADBEEF)
         $display("FAIL word_load lat=%0d wr=%0d err=%b rd=%h want 2 0 0 deadbeef",
                  lat, wc, err, rd);
      else n_pass++;
      n_checks++;
      if (rr_m0_rdata !== 32'hDEADBEEF)
         $display("FAIL rdata_hold got %h want deadbeef", rr_m0_rdata);
      else n_pass++;
   endtask

   task automatic test_byte();
      int lat, wc; logic err; logic [31:0] rd; logic [3:0] be;
      run_access(1, 1'b1, 2'b00, 1'b0, 12'h013, 32'h00000080, lat, err, rd, wc, be);
      n_checks++;
      if (lat !== 2 || wc !== 1 || be !== 4'b1000 || mem[4] !== 32'h80ADBEEF)
         $display("FAIL byte_store lat=%0d wr=%0d be=%b mem=%h want 2 1 1000 80adbeef",
                  lat, wc, be, mem[4]);
      else n_pass++;
      run_access(1, 1'b0, 2'b00, 1'b1, 12'h013, 32'h0, lat, err, rd, wc, be);
      n_checks++;
      if (rd !== 32'hFFFFFF80 || err !== 1'b0)
         $display("FAIL byte_load_s rd=%h err=%b want ffffff80 0", rd, err);
      else n_pass++;
      run_access(1, 1'b0, 2'b00, 1'b0, 12'h013, 32'h0, lat, err, rd, wc, be);
      n_checks++;
      if (rd !== 32'h00000080) $display("FAIL byte_load_u rd=%h want 00000080", rd);
      else n_pass++;
      run_access(1, 1'b0, 2'b00, 1'b1, 12'h011, 32'h0, lat, err, rd, wc, be);
      n_checks++;
      if (rd !== 32'hFFFFFFBE) $display("FAIL byte1_load_s rd=%h want ffffffbe", rd);
      else n_pass++;
      run_access(0, 1'b0, 2'b01, 1'b1, 12'h012, 32'h0, lat, err, rd, wc, be);
      n_checks++;
      if (rd !== 32'hFFFF80AD || lat !== 2)
         $display("FAIL half_hi_load_s rd=%h lat=%0d want ffff80ad 2", rd, lat);
      else n_pass++;
      run_access(0, 1'b0, 2'b01, 1'b0, 12'h010, 32'h0, lat, err, rd, wc, be);
      n_checks++;
      if (rd !== 32'h0000BEEF) $display("FAIL half_lo_load_u rd=%h want 0000beef", rd);
      else n_pass++;
   endtask

   task automatic test_misaligned();
      int lat, wc; logic err; logic [31:0] rd; logic [3:0] be;
      run_access(0, 1'b0, 2'b01, 1'b0, 12'h011, 32'h0, lat, err, rd, wc, be);
      n_checks++;
      if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || wc !== 0)
         $display("FAIL mis_half lat=%0d err=%b rd=%h wr=%0d want 1 1 0 0", lat, err, rd, wc);
      else n_pass++;
      run_access(0, 1'b1, 2'b10, 1'b0, 12'h002, 32'h12345678, lat, err, rd, wc, be);
      n_checks++;
      if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || wc !== 0 || mem[0] !== 32'h0)
         $display("FAIL mis_word lat=%0d err=%b rd=%h wr=%0d mem=%h want 1 1 0 0 0",
                  lat, err, rd, wc, mem[0]);
      else n_pass++;
      run_access(1, 1'b0, 2'b11, 1'b0, 12'h000, 32'h0, lat, err, rd, wc, be);
      n_checks++;
      if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || wc !== 0)
         $display("FAIL illegal_size lat=%0d err=%b rd=%h wr=%0d want 1 1 0 0", lat, err, rd, wc);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int lat, wc; logic err; logic [31:0] rd; logic [3:0] be;
      m1_we = 1'b0; m1_size = 2'b00; m1_signed = 1'b1; m1_addr = 12'h013; m1_req = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (rr_busy !== 1'b1 || rr_dm_be !== 4'b1000)
         $display("FAIL mid_access busy=%b be=%b want 1 1000", rr_busy, rr_dm_be);
      else n_pass++;
      rst_n = 1'b0; m1_req = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (rr_m1_ack !== 1'b0 || rr_busy !== 1'b0 || rr_m1_rdata !== 32'h0 ||
          rr_dm_wr !== 1'b0 || rr_dm_be !== 4'h0 || rr_dm_addr !== 10'h0 || rr_dm_signed !== 1'b0)
         $display("FAIL mid_reset ack=%b busy=%b rd=%h wr=%b be=%b addr=%h sg=%b want all 0",
                  rr_m1_ack, rr_busy, rr_m1_rdata, rr_dm_wr, rr_dm_be, rr_dm_addr, rr_dm_signed);
      else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (rr_m1_ack !== 1'b0) $display("FAIL mid_late_ack got %b want 0", rr_m1_ack);
      else n_pass++;
      run_access(1, 1'b0, 2'b00, 1'b0, 12'h013, 32'h0, lat, err, rd, wc, be);
      n_checks++;
      if (lat !== 2 || rd !== 32'h00000080 || err !== 1'b0)
         $display("FAIL after_reset lat=%0d rd=%h err=%b want 2 00000080 0", lat, rd, err);
      else n_pass++;

      // Store interrupted in ACCESS: the falling-edge write still lands.
      m0_we = 1'b1; m0_size = 2'b00; m0_signed = 1'b0; m0_addr = 12'h020;
      m0_wdata = 32'h0000005A; m0_req = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0; m0_req = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (mem[8] !== 32'h0000005A || rr_m0_ack !== 1'b0)
         $display("FAIL reset_in_access mem=%h ack=%b want 0000005a 0", mem[8], rr_m0_ack);
      else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset on the granting edge: nothing reaches the memory.
      m0_we = 1'b1; m0_size = 2'b10; m0_addr = 12'h030; m0_wdata = 32'h11223344;
      m0_req = 1'b1; rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; m0_req = 1'b0;
      wc = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (rr_dm_wr) wc++;
      end
      n_checks++;
      if (wc !== 0 || mem[12] !== 32'h0 || rr_m0_ack !== 1'b0)
         $display("FAIL reset_at_grant wr=%0d mem=%h ack=%b want 0 0 0", wc, mem[12], rr_m0_ack);
      else n_pass++;
   endtask

   task automatic test_contention();
      int order[4];
      int n_rr, fx0, fx1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m0_we = 1'b0; m0_size = 2'b10; m0_signed = 1'b0; m0_addr = 12'h010;
      m1_we = 1'b0; m1_size = 2'b10; m1_signed = 1'b0; m1_addr = 12'h020;
      m0_req = 1'b1; m1_req = 1'b1;
      n_rr = 0; fx0 = 0; fx1 = 0;
      for (int c = 0; c < 30 && n_rr < 4; c++) begin
         @(posedge clk); #1;
         if (rr_m0_ack) begin order[n_rr] = 0; n_rr++; end
         if (rr_m1_ack) begin order[n_rr] = 1; n_rr++; end
         if (fx_m0_ack) fx0++;
         if (fx_m1_ack) fx1++;
      end
      m0_req = 1'b0; m1_req = 1'b0;
      n_checks++;
      if (n_rr !== 4) $display("FAIL rr_grant_count got %0d want 4", n_rr);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (n_rr > i && order[i] === i % 2) n_pass++;
         else $display("FAIL rr_order[%0d] got %0d want %0d", i, order[i], i % 2);
      end
      n_checks++;
      if (rr_m0_rdata !== 32'h80ADBEEF || rr_m1_rdata !== 32'h0000005A)
         $display("FAIL rr_data m0=%h m1=%h want 80adbeef 0000005a", rr_m0_rdata, rr_m1_rdata);
      else n_pass++;
      n_checks++;
      if (fx0 !== 4 || fx1 !== 0)
         $display("FAIL fixed_prio m0_acks=%0d m1_acks=%0d want 4 0", fx0, fx1);
      else n_pass++;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      rst_n = 1'b0;
      m0_req = 1'b0; m0_we = 1'b0; m0_size = 2'b00; m0_signed = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_size = 2'b00; m1_signed = 1'b0; m1_addr = '0; m1_wdata = '0;
      test_reset();
      test_word();
      test_byte();
      test_misaligned();
      test_reset_mid();
      test_contention();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
